// File: rtl/clock_divider_prog.sv
// Runtime-programmable integer clock divider with a glitch-free shadowed ratio,
// clean start/stop on period boundaries, and a one-cycle enable pulse per rising edge.
module clock_divider_prog #(
    parameter int CNT_WIDTH   = 8,
    parameter int DEFAULT_DIV = 2
) (
    input  logic                 clk_in,
    input  logic                 rst,
    input  logic                 en,
    input  logic [CNT_WIDTH-1:0] div_val,
    input  logic                 div_load,
    output logic                 div_pending,
    output logic                 clk_out,
    output logic                 clk_out_b,
    output logic                 clk_en_pulse,
    output logic                 running
);

    typedef enum logic {IDLE, RUN} state_t;

    localparam logic [CNT_WIDTH-1:0] RATIO_MIN     = CNT_WIDTH'(2);
    localparam logic [CNT_WIDTH-1:0] DEFAULT_RAW   = CNT_WIDTH'(DEFAULT_DIV);
    localparam logic [CNT_WIDTH-1:0] DEFAULT_RATIO = (DEFAULT_RAW < RATIO_MIN) ? RATIO_MIN : DEFAULT_RAW;

    // Ratios 0 and 1 have no meaningful waveform; they behave as divide-by-2.
    function automatic logic [CNT_WIDTH-1:0] clamp_ratio(input logic [CNT_WIDTH-1:0] v);
        return (v < RATIO_MIN) ? RATIO_MIN : v;
    endfunction

    state_t               state_reg;
    logic [CNT_WIDTH-1:0] cnt_reg;
    logic [CNT_WIDTH-1:0] ratio_reg;
    logic [CNT_WIDTH-1:0] shadow_reg;
    logic                 pending_reg;
    logic                 clk_out_reg;
    logic                 clk_out_b_reg;
    logic                 pulse_reg;
    logic                 running_reg;

    logic [CNT_WIDTH:0]   cnt_inc;
    logic [CNT_WIDTH:0]   half_len;
    logic                 boundary;
    logic                 apply_point;
    logic                 high_next;
    logic [CNT_WIDTH-1:0] ratio_next;

    always_comb begin
        cnt_inc     = {1'b0, cnt_reg} + 1'b1;
        half_len    = ({1'b0, ratio_reg} + 1'b1) >> 1;
        high_next   = (cnt_inc < half_len);
        boundary    = (state_reg == RUN) && (cnt_reg == ratio_reg - CNT_WIDTH'(1));
        // IDLE has no period in flight, so every IDLE edge is a safe switch point.
        apply_point = (state_reg == IDLE) || boundary;
        ratio_next  = ratio_reg;
        if (div_load) begin
            ratio_next = clamp_ratio(div_val);
        end else if (pending_reg) begin
            ratio_next = clamp_ratio(shadow_reg);
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst) begin
            state_reg     <= IDLE;
            cnt_reg       <= '0;
            ratio_reg     <= DEFAULT_RATIO;
            shadow_reg    <= '0;
            pending_reg   <= 1'b0;
            clk_out_reg   <= 1'b0;
            clk_out_b_reg <= 1'b1;
            pulse_reg     <= 1'b0;
            running_reg   <= 1'b0;
        end else begin
            if (div_load) begin
                shadow_reg <= div_val;
            end
            if (apply_point) begin
                ratio_reg   <= ratio_next;
                pending_reg <= 1'b0;
            end else if (div_load) begin
                pending_reg <= 1'b1;
            end

            case (state_reg)
                IDLE: begin
                    cnt_reg <= '0;
                    if (en) begin
                        state_reg     <= RUN;
                        clk_out_reg   <= 1'b1;
                        clk_out_b_reg <= 1'b0;
                        pulse_reg     <= 1'b1;
                        running_reg   <= 1'b1;
                    end else begin
                        clk_out_reg   <= 1'b0;
                        clk_out_b_reg <= 1'b1;
                        pulse_reg     <= 1'b0;
                        running_reg   <= 1'b0;
                    end
                end
                RUN: begin
                    if (boundary) begin
                        cnt_reg <= '0;
                        // en is only honoured here, so a stop never cuts a period short.
                        if (en) begin
                            clk_out_reg   <= 1'b1;
                            clk_out_b_reg <= 1'b0;
                            pulse_reg     <= 1'b1;
                        end else begin
                            state_reg     <= IDLE;
                            clk_out_reg   <= 1'b0;
                            clk_out_b_reg <= 1'b1;
                            pulse_reg     <= 1'b0;
                            running_reg   <= 1'b0;
                        end
                    end else begin
                        cnt_reg       <= cnt_inc[CNT_WIDTH-1:0];
                        clk_out_reg   <= high_next;
                        clk_out_b_reg <= ~high_next;
                        pulse_reg     <= 1'b0;
                    end
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    assign div_pending  = pending_reg;
    assign clk_out      = clk_out_reg;
    assign clk_out_b    = clk_out_b_reg;
    assign clk_en_pulse = pulse_reg;
    assign running      = running_reg;

endmodule

// File: tb/tb_clock_divider_prog.sv
// Directed bench for clock_divider_prog: waveform patterns per ratio, clamp,
// shadowed ratio change, clean stop and mid-run reset.
module tb_clock_divider_prog;

    localparam int CW = 8;

    logic          clk_in = 1'b0;
    logic          rst;
    logic          en;
    logic [CW-1:0] div_val;
    logic          div_load;
    logic          div_pending;
    logic          clk_out;
    logic          clk_out_b;
    logic          clk_en_pulse;
    logic          running;

    int total = 0;
    int bad   = 0;

    clock_divider_prog #(
        .CNT_WIDTH   (CW),
        .DEFAULT_DIV (2)
    ) dut (
        .clk_in       (clk_in),
        .rst          (rst),
        .en           (en),
        .div_val      (div_val),
        .div_load     (div_load),
        .div_pending  (div_pending),
        .clk_out      (clk_out),
        .clk_out_b    (clk_out_b),
        .clk_en_pulse (clk_en_pulse),
        .running      (running)
    );

    always #5 clk_in = ~clk_in;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end else begin
            $display("ok   %s: %0h", tag, got);
        end
    endtask

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    task automatic check_idle(input string tag);
        check({tag, ".clk_out"}, 32'(clk_out), 32'd0);
        check({tag, ".clk_out_b"}, 32'(clk_out_b), 32'd1);
        check({tag, ".running"}, 32'(running), 32'd0);
        check({tag, ".pulse"}, 32'(clk_en_pulse), 32'd0);
    endtask

    // Checks the current cycle as cnt=0 of a period, then ticks through reps periods.
    // pat holds the clk_out sequence MSB-first over len cycles.
    task automatic check_pattern(input string tag, input logic [15:0] pat, input int len, input int reps);
        for (int i = 0; i < len * reps; i++) begin
            if (i > 0) tick();
            check($sformatf("%s.out[%0d]", tag, i), 32'(clk_out), 32'(pat[len - 1 - (i % len)]));
            check($sformatf("%s.out_b[%0d]", tag, i), 32'(clk_out_b), 32'(!pat[len - 1 - (i % len)]));
            check($sformatf("%s.pulse[%0d]", tag, i), 32'(clk_en_pulse), 32'((i % len) == 0));
        end
        check({tag, ".running"}, 32'(running), 32'd1);
    endtask

    // From IDLE: load ratio, start, check pattern, stop at the final boundary.
    task automatic run_ratio(input string tag, input logic [CW-1:0] v, input logic [15:0] pat, input int len);
        div_val = v; div_load = 1'b1;
        tick();
        div_load = 1'b0;
        tick();
        en = 1'b1;
        tick();
        check_pattern(tag, pat, len, 3);
        en = 1'b0;
        tick();
        check_idle({tag, ".stop"});
    endtask

    initial begin
        rst = 1'b1; en = 1'b0; div_val = '0; div_load = 1'b0;
        tick();
        tick();
        check_idle("reset");
        check("reset.pending", 32'(div_pending), 32'd0);
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            check_idle($sformatf("hold%0d", i));
        end

        run_ratio("n4", 8'd4, 16'b1100, 4);
        run_ratio("n5", 8'd5, 16'b11100, 5);
        run_ratio("n0", 8'd0, 16'b10, 2);
        run_ratio("n1", 8'd1, 16'b10, 2);

        // Mid-period change 6 -> 3, loaded while cnt=1
        div_val = 8'd6; div_load = 1'b1;
        tick();
        div_load = 1'b0;
        en = 1'b1;
        tick();                                  // cnt=0
        check("mid.c0.out", 32'(clk_out), 32'd1);
        tick();                                  // cnt=1
        div_val = 8'd3; div_load = 1'b1;
        tick();                                  // cnt=2
        div_load = 1'b0;
        check("mid.c2.pending", 32'(div_pending), 32'd1);
        check("mid.c2.out", 32'(clk_out), 32'd1);
        tick();                                  // cnt=3
        check("mid.c3.out", 32'(clk_out), 32'd0);
        tick();
        tick();                                  // cnt=5
        check("mid.c5.out", 32'(clk_out), 32'd0);
        check("mid.c5.pending", 32'(div_pending), 32'd1);
        check("mid.c5.pulse", 32'(clk_en_pulse), 32'd0);
        tick();                                  // boundary edge
        check("mid.bnd.pending", 32'(div_pending), 32'd0);
        check_pattern("n3", 16'b110, 3, 2);
        en = 1'b0;
        tick();
        check_idle("mid.stop");

        // Clean stop: N=8, en dropped at cnt=2
        div_val = 8'd8; div_load = 1'b1;
        tick();
        div_load = 1'b0;
        en = 1'b1;
        tick();                                  // cnt=0
        tick();
        tick();                                  // cnt=2
        en = 1'b0;
        for (int c = 3; c < 8; c++) begin
            tick();
            check($sformatf("stop.c%0d.out", c), 32'(clk_out), 32'(c < 4));
            check($sformatf("stop.c%0d.run", c), 32'(running), 32'd1);
        end
        tick();
        check_idle("stop.idle");
        tick();
        check_idle("stop.idle2");

        // en glitch low for one cycle mid-period: no interruption
        en = 1'b1;
        tick();                                  // cnt=0
        tick(); tick(); tick();                  // cnt=3
        en = 1'b0;
        tick();                                  // cnt=4
        en = 1'b1;
        check("glitch.c4.run", 32'(running), 32'd1);
        tick(); tick(); tick();                  // cnt=7
        check("glitch.c7.out", 32'(clk_out), 32'd0);
        tick();
        check("glitch.wrap.out", 32'(clk_out), 32'd1);
        check("glitch.wrap.pulse", 32'(clk_en_pulse), 32'd1);
        check("glitch.wrap.run", 32'(running), 32'd1);
        en = 1'b0;
        for (int c = 1; c < 9; c++) tick();      // finish period, drop to IDLE
        check_idle("glitch.stop");

        // Reset mid-run: N=7, pending load, rst at cnt=3
        div_val = 8'd7; div_load = 1'b1;
        tick();
        div_load = 1'b0;
        en = 1'b1;
        tick();                                  // cnt=0
        tick(); tick();                          // cnt=2
        div_val = 8'd5; div_load = 1'b1;
        tick();                                  // cnt=3
        div_load = 1'b0;
        check("rst.pre.pending", 32'(div_pending), 32'd1);
        check("rst.pre.out", 32'(clk_out), 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_idle("rst.post");
        check("rst.post.pending", 32'(div_pending), 32'd0);
        en = 1'b1;
        tick();
        check_pattern("rst.n2", 16'b10, 2, 3);
        en = 1'b0;
        tick();
        check_idle("rst.stop");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
